// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolve unit: prediction queue
// entry layout, resolve FSM states and default sizing.
package bru_pkg;

   localparam logic [31:0] PC_STEP              = 32'd4;
   localparam int          DEPTH_DEFAULT        = 4;
   localparam int          FLUSH_CYCLES_DEFAULT = 2;

   typedef struct packed {
      logic [31:0] pc;
      logic        entry_found;
      logic        pred_taken;
      logic [31:0] pred_pc;
   } pred_entry_t;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } bru_state_t;

endpackage

// File: rtl/bru_pred_fifo.sv
// In-order circular buffer of fetch predictions; clear wins over push/pop.
// Depth must be a power of two so the pointers wrap on their own.
module bru_pred_fifo
   import bru_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_clear,
   input  logic          i_push,
   input  pred_entry_t   i_din,
   input  logic          i_pop,
   output pred_entry_t   o_head,
   output logic [CW-1:0] o_count,
   output logic          o_full,
   output logic          o_empty
);

   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   pred_entry_t   r_mem [DEPTH];
   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic          w_wr;

   assign w_wr    = i_push && !i_clear && !reset;
   assign o_head  = r_mem[r_head];
   assign o_count = r_count;
   assign o_full  = (r_count == DEPTH_C);
   assign o_empty = (r_count == '0);

   // Entry storage, no reset needed: only slots covered by count are read.
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[r_tail] <= i_din;
      end
   end

   // Pointer and occupancy tracking.
   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_tail <= r_tail + AW'(1);
         end
         if (i_pop) begin
            r_head <= r_head + AW'(1);
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves queued fetch predictions at execute, drives BTB updates and the
// misprediction redirect/flush. Optional perf counters: BRU_PERF_CNT_EN.
module branch_resolve_unit
   import bru_pkg::*;
#(
   parameter int DEPTH        = DEPTH_DEFAULT,
   parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        f_valid,
   input  logic [31:0] f_pc,
   input  logic        f_entry_found,
   input  logic        f_pred_taken,
   input  logic [31:0] f_pred_pc,
   output logic        f_ready,
   input  logic        e_valid,
   input  logic        e_is_branch,
   input  logic        e_taken,
   input  logic [31:0] e_target,
   output logic        btb_write,
   output logic        state_write,
   output logic        state_change,
   output logic        branch_e,
   output logic [31:0] branch_address,
   output logic [31:0] predicted_address,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        flush,
   output logic        err_underflow
`ifdef BRU_PERF_CNT_EN
   ,
   output logic [31:0] branch_count,
   output logic [31:0] mispredict_count
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [3:0] FLUSH_C = 4'(FLUSH_CYCLES);

   bru_state_t    r_state;
   bru_state_t    w_state_nxt;
   logic [3:0]    r_fcnt;
   logic [3:0]    w_fcnt_nxt;

   pred_entry_t   w_head;
   pred_entry_t   w_din;
   logic [CW-1:0] w_count;
   logic          w_full;
   logic          w_empty;
   logic          w_run;
   logic          w_pop;
   logic          w_push;
   logic          w_mispredict;
   logic [31:0]   w_fallthru;
   logic [31:0]   w_actual;
   logic [31:0]   w_predicted;

   assign w_run       = (r_state == RUN);
   assign f_ready     = !w_full && w_run;
   assign w_pop       = e_valid && w_run && !w_empty;
   assign w_fallthru  = w_head.pc + PC_STEP;
   assign w_actual    = (e_is_branch && e_taken) ? e_target : w_fallthru;
   assign w_predicted = (w_head.entry_found && w_head.pred_taken) ? w_head.pred_pc : w_fallthru;
   assign w_mispredict = w_pop && (w_actual != w_predicted);
   // A push racing a mispredict belongs to the wrong path and is dropped.
   assign w_push      = f_valid && f_ready && !w_mispredict;
   assign w_din       = '{pc: f_pc, entry_found: f_entry_found,
                          pred_taken: f_pred_taken, pred_pc: f_pred_pc};

   bru_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_clear (w_mispredict),
      .i_push  (w_push),
      .i_din   (w_din),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // FSM state and flush-hold counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= RUN;
         r_fcnt  <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_fcnt  <= w_fcnt_nxt;
      end
   end

   // Next-state: stay in FLUSH until the counter has run down to 1.
   always_comb begin
      w_state_nxt = r_state;
      w_fcnt_nxt  = r_fcnt;
      case (r_state)
         RUN: begin
            if (w_mispredict) begin
               w_state_nxt = FLUSH;
               w_fcnt_nxt  = FLUSH_C;
            end else begin
               w_state_nxt = RUN;
               w_fcnt_nxt  = 4'd0;
            end
         end
         FLUSH: begin
            if (r_fcnt <= 4'd1) begin
               w_state_nxt = RUN;
               w_fcnt_nxt  = 4'd0;
            end else begin
               w_state_nxt = FLUSH;
               w_fcnt_nxt  = r_fcnt - 4'd1;
            end
         end
         default: begin
            w_state_nxt = RUN;
            w_fcnt_nxt  = 4'd0;
         end
      endcase
   end

   // BTB-side and redirect outputs, valid for one cycle after a pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         btb_write         <= 1'b0;
         state_write       <= 1'b0;
         state_change      <= 1'b0;
         branch_e          <= 1'b0;
         branch_address    <= 32'd0;
         predicted_address <= 32'd0;
         redirect          <= 1'b0;
         redirect_pc       <= 32'd0;
         flush             <= 1'b0;
         err_underflow     <= 1'b0;
      end else begin
         btb_write         <= w_pop && e_is_branch && !w_head.entry_found && e_taken;
         state_write       <= w_pop && e_is_branch && w_head.entry_found;
         state_change      <= w_pop && e_is_branch && e_taken;
         branch_e          <= w_pop && e_is_branch;
         branch_address    <= w_pop ? w_head.pc : 32'd0;
         predicted_address <= w_pop ? e_target : 32'd0;
         redirect          <= w_mispredict;
         flush             <= w_mispredict;
         redirect_pc       <= w_mispredict ? w_actual : 32'd0;
         err_underflow     <= err_underflow || (e_valid && w_run && w_empty);
      end
   end

`ifdef BRU_PERF_CNT_EN
   // Saturating performance counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         branch_count     <= 32'd0;
         mispredict_count <= 32'd0;
      end else begin
         if (w_pop && e_is_branch && (branch_count != 32'hFFFF_FFFF)) begin
            branch_count <= branch_count + 32'd1;
         end
         if (w_mispredict && (mispredict_count != 32'hFFFF_FFFF)) begin
            mispredict_count <= mispredict_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Sits between the fetch stage (BTB lookup outputs) and the execute stage.
- Keeps an in-order queue of per-instruction fetch predictions and resolves each one when its instruction leaves execute.
- Produces the BTB update controls (write, state update, global-history update) and the misprediction redirect/flush to fetch and the hazard unit.
- Single pipe; BTB samples its write inputs on negedge, so all BTB-side outputs are posedge-registered.

Parameters:
- DEPTH, 4, prediction queue entries (power of 2, ≥2); equals max in-flight instructions fetch→execute.
- FLUSH_CYCLES, 2, cycles held in FLUSH after a redirect (1..15).

Ports:
- clk  in  1  clock, posedge
- reset  in  1  reset, synchronous, active-high
- f_valid  in  1  fetch presents an instruction this cycle
- f_pc  in  32  fetched PC
- f_entry_found  in  1  BTB hit for f_pc
- f_pred_taken  in  1  BTB taken prediction
- f_pred_pc  in  32  BTB predicted target
- f_ready  out  1  queue can accept; fetch stalls when low
- e_valid  in  1  oldest in-flight instruction leaves execute this cycle
- e_is_branch  in  1  that instruction is a branch
- e_taken  in  1  branch resolved taken
- e_target  in  32  resolved branch target
- btb_write  out  1  allocate a new BTB entry
- state_write  out  1  update an existing BTB entry's state
- state_change  out  1  resolved direction (1 = taken)
- branch_e  out  1  update global history
- branch_address  out  32  PC of the resolved branch
- predicted_address  out  32  resolved target
- redirect  out  1  one-cycle pulse: load redirect_pc into the fetch PC
- redirect_pc  out  32  correct next PC
- flush  out  1  squash younger decode/execute instructions
- err_underflow  out  1  sticky: e_valid arrived with the queue empty

Behaviour:
- Reset: all outputs 0, queue empty (count = 0, head = tail = 0), FSM in RUN. Reset asserted mid-operation discards everything on the next edge.
- Push: when f_valid && f_ready && state == RUN && !mispredict_now, write {f_pc, f_entry_found, f_pred_taken, f_pred_pc} at tail.
- f_ready = (count < DEPTH) && state == RUN. Combinational, no dependence on e_valid.
- Pop: e_valid in RUN with count > 0 pops head. Push and pop in the same cycle are allowed; count is unchanged. Pointers wrap modulo DEPTH.
- e_valid with count == 0: no pop, no outputs, err_underflow set until reset.
- Resolve, combinational on the head entry h:
  - actual = (e_is_branch && e_taken) ? e_target : h.pc + 4
  - predicted = (h.entry_found && h.pred_taken) ? h.pred_pc : h.pc + 4
  - mispredict_now = e_valid && count > 0 && actual != predicted
  - Adds are 32-bit and wrap.
- BTB outputs: registered, valid exactly one cycle after a popping e_valid, 0 otherwise.
  - branch_e = e_is_branch
  - state_write = e_is_branch && h.entry_found
  - btb_write = e_is_branch && !h.entry_found && e_taken
  - state_change = e_taken & e_is_branch
  - branch_address = h.pc
  - predicted_address = e_target
- Non-branch instructions pop with all write strobes 0. They can still mispredict, on a stale BTB hit; redirect corrects it.
- FSM RUN:
  - On mispredict_now, the next edge sets redirect = flush = 1 (one cycle) and redirect_pc = actual.
  - The same edge clears the queue, discarding the simultaneous push, and loads the flush counter with FLUSH_CYCLES.
  - State goes to FLUSH.
- FSM FLUSH:
  - f_ready = 0; e_valid is ignored (squashed instructions: no pop, no error, no BTB strobes).
  - Counter decrements each cycle; at 1, the next state is RUN.
  - BTB outputs from the mispredicting branch still fire in the redirect cycle.
- Back-to-back: a new mispredict can only occur in RUN, so redirect pulses are at least FLUSH_CYCLES+1 cycles apart.

Optional Feature:
- Macro BRU_PERF_CNT_EN.
- Defined: adds outputs branch_count[31:0] and mispredict_count[31:0].
  - branch_count increments on each popping e_valid with e_is_branch.
  - mispredict_count increments on each redirect.
  - Both saturate at all-ones and clear on reset.
- Undefined: ports absent, no counter logic.

Decomposition:
- Package bru_pkg holds:
  - pred_entry_t struct {pc, entry_found, pred_taken, pred_pc}
  - state enum {RUN, FLUSH}
  - PC_STEP = 4
  - DEPTH_DEFAULT = 4
  - FLUSH_CYCLES_DEFAULT = 2
- Sub-module bru_pred_fifo: circular buffer with push/pop/clear, count, full/empty.

Test Plan:
- Reset → all outputs 0, f_ready = 1. Push 4 entries with e_valid = 0 → f_ready = 0 after the 4th push; a 5th f_valid is not stored.
- Push pc = 0x100, found = 0; e_valid with branch, taken, target 0x200 → next cycle btb_write = 1, branch_address = 0x100, predicted_address = 0x200, branch_e = 1, redirect = 1, redirect_pc = 0x200, flush = 1; f_ready = 0 for 2 cycles, then 1.
- Push pc = 0x40, found = 1, pred_taken = 1, pred_pc = 0x80; resolve taken to 0x80 → state_write = 1, state_change = 1, redirect = 0, queue count decrements.
- Same entry resolved not taken → redirect_pc = 0x44, state_change = 0. A push in the same cycle is dropped and count = 0 afterwards.
- e_valid with an empty queue → err_underflow = 1 and stays 1; no strobes. Reset clears it.
- Full queue with push and pop in the same cycle, over 3×DEPTH operations → order preserved across pointer wrap; branch_address sequence matches push order.
